// File: rtl/processor_memory_dp.sv
// processor_memory_dp: dual-port word memory with two identical Avalon-MM slaves.
//
// Ports:
//   clk, reset_n       single rising-edge clock; asynchronous active-low reset
//   clken, freeze      global enable; freeze behaves exactly like clken=0
//   reset_req          blocks array access; the read pipeline still advances
//   sN_address         word address (N = 1, 2)
//   sN_chipselect      slave select
//   sN_read/sN_write   requests; a read together with a write performs only the write
//   sN_byteenable      write byte-lane enables
//   sN_writedata       write data
//   sN_readdata        registered read data, held until the next readdatavalid
//   sN_readdatavalid   one-cycle read qualifier, READ_LATENCY enabled cycles after accept
//   sN_waitrequest     stall (reset, clearing, or not enabled)
module processor_memory_dp #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 5120,
  parameter int ADDR_W         = 13,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b0,
  parameter     INIT_FILE      = "processor_memory.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                reset_req,
  input  logic                freeze,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StReset, StClear, StReady} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // Power-up contents are supplied by the FPGA flow's memory-init mechanism keyed on INIT_FILE.
  logic unused_init;
  assign unused_init = ^INIT_FILE;

  logic pipe_en;  // read pipeline advances
  logic acc_en;   // array may be accessed
  logic wait_all;

  assign pipe_en  = clken & ~freeze;
  assign acc_en   = pipe_en & ~reset_req;
  assign wait_all = (state_q != StReady) | ~acc_en;

  // Per-port views so both slaves share one description.
  logic [ADDR_W-1:0] addr     [2];
  logic              cs       [2];
  logic              rd       [2];
  logic              wr       [2];
  logic [BE_W-1:0]   be       [2];
  logic [DATA_W-1:0] wdata    [2];
  logic              acc_rd   [2];
  logic              acc_wr   [2];
  logic              in_range [2];
  logic [IDX_W-1:0]  idx      [2];
  logic [DATA_W-1:0] rword    [2];
  logic [DATA_W-1:0] rdata    [2];
  logic              rvalid   [2];

  assign addr[0]  = s1_address;
  assign cs[0]    = s1_chipselect;
  assign rd[0]    = s1_read;
  assign wr[0]    = s1_write;
  assign be[0]    = s1_byteenable;
  assign wdata[0] = s1_writedata;
  assign addr[1]  = s2_address;
  assign cs[1]    = s2_chipselect;
  assign rd[1]    = s2_read;
  assign wr[1]    = s2_write;
  assign be[1]    = s2_byteenable;
  assign wdata[1] = s2_writedata;

  assign s1_readdata      = rdata[0];
  assign s1_readdatavalid = rvalid[0];
  assign s1_waitrequest   = wait_all;
  assign s2_readdata      = rdata[1];
  assign s2_readdatavalid = rvalid[1];
  assign s2_waitrequest   = wait_all;

  // Controller: RESET -> (CLEAR ->) READY. The clear counter only steps on access-enabled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StReset;
      clr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StReset: begin
          clr_cnt_q <= '0;
          state_q   <= CLEAR_ON_RESET ? StClear : StReady;
        end
        StClear: begin
          if (acc_en) begin
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_q <= StReady;
            else clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        StReady: ;
        default: state_q <= StReset;
      endcase
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              st_v;
    logic [DATA_W-1:0] st_d;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    assign acc_wr[p]   = cs[p] & wr[p] & ~wait_all;
    assign acc_rd[p]   = cs[p] & rd[p] & ~wr[p] & ~wait_all;
    assign in_range[p] = 32'(addr[p]) < 32'(DEPTH);
    assign idx[p]      = addr[p][IDX_W-1:0];
    // Out-of-range reads return zero; the array read sees pre-edge contents (read-old-data).
    assign rword[p]    = in_range[p] ? mem[idx[p]] : '0;

    if (READ_LATENCY == 2) begin : g_lat2
      logic              p_v_q;
      logic [DATA_W-1:0] p_d_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          p_v_q <= 1'b0;
          p_d_q <= '0;
        end else if (pipe_en) begin
          p_v_q <= acc_rd[p];
          p_d_q <= rword[p];
        end
      end
      assign st_v = p_v_q;
      assign st_d = p_d_q;
    end else begin : g_lat1
      assign st_v = acc_rd[p];
      assign st_d = rword[p];
    end

    // Valid drops on stalled edges so it is never high for more than one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= pipe_en & st_v;
        if (pipe_en && st_v) rdata_q <= st_d;
      end
    end

    assign rvalid[p] = rvalid_q;
    assign rdata[p]  = rdata_q;
  end

  // Array writes: port 2 first, port 1 last so port 1 wins per enabled lane on a collision.
  always_ff @(posedge clk) begin
    if (state_q == StClear && acc_en) mem[clr_cnt_q[IDX_W-1:0]] <= '0;
    for (int p = 1; p >= 0; p--) begin
      if (acc_wr[p] && in_range[p]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[p][b]) mem[idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_processor_memory_dp.sv
// Bench for processor_memory_dp: two instances share one stimulus stream.
//   dut_a: READ_LATENCY=1, no clear; dut_b: READ_LATENCY=2, CLEAR_ON_RESET=1. Both DEPTH=16.
// A behavioural model (word array + per-port queues of reads due on an enabled-cycle count)
// predicts waitrequest, readdatavalid and readdata every cycle.
module tb_processor_memory_dp;
  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int AW  = 5;

  logic clk = 1'b0;
  logic reset_n, clken, reset_req, freeze;
  logic [AW-1:0] addr [2];
  logic          cs   [2];
  logic          rd   [2];
  logic          wr   [2];
  logic [3:0]    be   [2];
  logic [DW-1:0] wd   [2];

  // Outputs flattened as index d*2+p (d: 0=dut_a, 1=dut_b; p: 0=s1, 1=s2).
  logic [DW-1:0] rdata [4];
  logic          rdv   [4];
  logic          wreq  [4];

  always #5 clk = ~clk;

  processor_memory_dp #(
    .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .freeze(freeze),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata[0]),
    .s1_readdatavalid(rdv[0]), .s1_waitrequest(wreq[0]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata[1]),
    .s2_readdatavalid(rdv[1]), .s2_waitrequest(wreq[1])
  );

  processor_memory_dp #(
    .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .freeze(freeze),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata[2]),
    .s1_readdatavalid(rdv[2]), .s1_waitrequest(wreq[2]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata[3]),
    .s2_readdatavalid(rdv[3]), .s2_waitrequest(wreq[3])
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
  } rd_item_t;

  // Reference model state.
  logic [31:0] mm [2][DEP];   // word contents per instance
  logic [3:0]  mk [2][DEP];   // which byte lanes hold a known value
  rd_item_t    rq [4][$];     // reads in flight per instance/port
  int          clear_left [2];
  bit          in_reset   [2];
  bit          exp_v      [4];
  logic [31:0] exp_rd     [4];
  bit          exp_known  [4];
  int          en_cnt;
  logic        last_wait_a, last_wait_b;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    clken = 1'b1; freeze = 1'b0; reset_req = 1'b0;
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; be[p] = '0; wd[p] = '0;
    end
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input logic [AW-1:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    cs[p] = 1'b1; rd[p] = r; wr[p] = w; addr[p] = a; be[p] = b; wd[p] = d;
  endtask

  // Called just after a negedge with inputs already applied; models the next posedge and
  // compares registered outputs at the following negedge.
  task automatic step();
    logic     pe, ae, busy;
    rd_item_t it;
    int       a;
    #1;
    pe = clken & ~freeze;
    ae = pe & ~reset_req;
    if (pe) en_cnt++;
    last_wait_a = wreq[0];
    last_wait_b = wreq[2];
    for (int d = 0; d < 2; d++) begin
      busy = in_reset[d] || (clear_left[d] > 0) || !ae;
      for (int p = 0; p < 2; p++)
        check_eq($sformatf("waitreq d%0d s%0d", d, p + 1), 32'(wreq[d*2+p]), 32'(busy));
      if (in_reset[d]) begin
        in_reset[d]   = 1'b0;
        clear_left[d] = (d == 1) ? DEP : 0;
      end else if (clear_left[d] > 0) begin
        if (ae) begin
          mm[d][DEP-clear_left[d]] = '0;
          mk[d][DEP-clear_left[d]] = 4'hF;
          clear_left[d]--;
        end
      end else if (ae) begin
        for (int p = 0; p < 2; p++) begin
          if (cs[p] && rd[p] && !wr[p]) begin
            a = int'(addr[p]);
            it.due   = en_cnt + ((d == 1) ? 2 : 1) - 1;
            it.data  = (a < DEP) ? mm[d][a] : 32'h0;
            it.known = (a >= DEP) || (mk[d][a] == 4'hF);
            rq[d*2+p].push_back(it);
          end
        end
        for (int p = 1; p >= 0; p--) begin
          a = int'(addr[p]);
          if (cs[p] && wr[p] && a < DEP) begin
            for (int b = 0; b < 4; b++) begin
              if (be[p][b]) begin
                mm[d][a][b*8 +: 8] = wd[p][b*8 +: 8];
                mk[d][a][b] = 1'b1;
              end
            end
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (pe && rq[d*2+p].size() > 0 && rq[d*2+p][0].due == en_cnt) begin
          it = rq[d*2+p].pop_front();
          exp_v[d*2+p]     = 1'b1;
          exp_rd[d*2+p]    = it.data;
          exp_known[d*2+p] = it.known;
        end else begin
          exp_v[d*2+p] = 1'b0;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rdvalid d%0d s%0d", i / 2, i % 2 + 1), 32'(rdv[i]), 32'(exp_v[i]));
      if (exp_known[i])
        check_eq($sformatf("rdata d%0d s%0d", i / 2, i % 2 + 1), rdata[i], exp_rd[i]);
    end
  endtask

  // Holds reset for n cycles starting at a negedge; releases at a negedge.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      in_reset[d]   = 1'b1;
      clear_left[d] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      rq[i].delete();
      exp_v[i] = 1'b0; exp_rd[i] = '0; exp_known[i] = 1'b1;
      check_eq("reset rdata", rdata[i], 32'h0);
      check_eq("reset rdvalid", 32'(rdv[i]), 32'h0);
      check_eq("reset waitreq", 32'(wreq[i]), 32'h1);
    end
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic idle_count(input int n, output int wa, output int wb);
    wa = 0; wb = 0;
    for (int i = 0; i < n; i++) begin
      idle();
      step();
      wa += int'(last_wait_a);
      wb += int'(last_wait_b);
    end
  endtask

  initial begin
    int wa, wb, mask;
    en_cnt = 0;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEP; w++) begin mm[d][w] = '0; mk[d][w] = '0; end
    reset_n = 1'b1;
    idle();
    @(negedge clk);
    do_reset(3);

    // Startup: dut_b spends the RESET cycle plus 16 clear cycles stalled.
    idle_count(20, wa, wb);
    check_eq("startup stall a", 32'(wa), 32'd1);
    check_eq("startup stall b", 32'(wb), 32'd17);

    // Byte-lane write.
    idle(); set_port(0, 0, 1, 5, 4'hF, 32'hAABBCCDD); step();
    idle(); set_port(0, 0, 1, 5, 4'b0101, 32'h11223344); step();
    idle(); set_port(0, 1, 0, 5, 4'h0, 32'h0); step();
    check_eq("bytelane valid a", 32'(rdv[0]), 32'h1);
    check_eq("bytelane data a", rdata[0], 32'hAA22CC44);
    idle(); step();
    check_eq("bytelane single-cycle valid a", 32'(rdv[0]), 32'h0);
    check_eq("bytelane data b", rdata[2], 32'hAA22CC44);

    // Same-address collision.
    idle();
    set_port(0, 0, 1, 9, 4'b0011, 32'hFFFFFFFF);
    set_port(1, 0, 1, 9, 4'b1111, 32'h12345678);
    step();
    idle(); set_port(0, 1, 0, 9, 4'h0, 32'h0); step();
    check_eq("collision data a", rdata[0], 32'h1234FFFF);
    idle(); step();

    // Read-during-write across ports.
    idle(); set_port(0, 0, 1, 4, 4'hF, 32'h0BADF00D); step();
    idle();
    set_port(0, 0, 1, 4, 4'hF, 32'h5A5A5A5A);
    set_port(1, 1, 0, 4, 4'h0, 32'h0);
    step();
    check_eq("rdw old data a", rdata[1], 32'h0BADF00D);
    idle(); set_port(1, 1, 0, 4, 4'h0, 32'h0); step();
    check_eq("rdw new data a", rdata[1], 32'h5A5A5A5A);
    idle(); step();

    // Latency-2 burst with a clken=0 bubble.
    for (int i = 0; i < 3; i++) begin
      idle(); set_port(0, 0, 1, AW'(i), 4'hF, 32'h100 + i); step();
    end
    mask = 0;
    for (int s = 0; s < 6; s++) begin
      idle();
      if (s < 4) set_port(0, 1, 0, (s < 2) ? AW'(s) : AW'(2), 4'h0, 32'h0);
      if (s == 2) clken = 1'b0;
      step();
      if (rdv[2]) mask |= (1 << s);
    end
    check_eq("lat2 valid pattern b", 32'(mask), 32'b011010);

    // Clear on reset: dut_b zeroes addr 3, dut_a retains it.
    idle(); set_port(0, 0, 1, 3, 4'hF, 32'hDEADBEEF); step();
    idle(); step();
    do_reset(2);
    idle_count(20, wa, wb);
    check_eq("clear stall b", 32'(wb), 32'd17);
    idle(); set_port(0, 1, 0, 3, 4'h0, 32'h0); step();
    check_eq("retained a", rdata[0], 32'hDEADBEEF);
    idle(); step();
    check_eq("cleared b", rdata[2], 32'h0);

    // Read in flight at reset, then reset mid-clear at word 7.
    idle(); set_port(0, 1, 0, 3, 4'h0, 32'h0); step();
    do_reset(2);
    idle_count(8, wa, wb);
    do_reset(2);
    idle_count(20, wa, wb);
    check_eq("restart clear stall b", 32'(wb), 32'd17);

    // Out-of-range read.
    idle(); set_port(0, 1, 0, 20, 4'h0, 32'h0); step();
    check_eq("oor valid a", 32'(rdv[0]), 32'h1);
    check_eq("oor data a", rdata[0], 32'h0);
    idle(); step();
    check_eq("oor valid b", 32'(rdv[2]), 32'h1);
    check_eq("oor data b", rdata[2], 32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(2);
        continue;
      end
      clken     = ($urandom_range(0, 9) != 0);
      freeze    = ($urandom_range(0, 19) == 0);
      reset_req = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < 2; p++) begin
        cs[p]   = ($urandom_range(0, 4) != 0);
        rd[p]   = 1'($urandom_range(0, 1));
        wr[p]   = ($urandom_range(0, 2) == 0);
        addr[p] = AW'($urandom_range(0, 19));
        be[p]   = 4'($urandom);
        wd[p]   = $urandom;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
